// File: rtl/run_monitor_if.sv
// Run-control bundle between run_monitor and its driver.
// The bench or cpu top side uses master, and run_monitor uses slave.
interface run_monitor_if #(
  parameter int NUM_CH = 1,
  parameter int PC_W   = 16,
  parameter int CNT_W  = 32
);
  logic                   start;
  logic [NUM_CH-1:0]      halt;
  logic [NUM_CH*PC_W-1:0] pc;
  logic                   core_rst_n;
  logic                   running;
  logic                   done;
  logic                   timeout;
  logic [CNT_W-1:0]       cycles;
  logic [NUM_CH-1:0]      halt_mask;
  logic [NUM_CH*PC_W-1:0] halt_pc;

  modport master (
    output start, halt, pc,
    input  core_rst_n, running, done, timeout, cycles, halt_mask, halt_pc
  );

  modport slave (
    input  start, halt, pc,
    output core_rst_n, running, done, timeout, cycles, halt_mask, halt_pc
  );
endinterface

// File: rtl/run_monitor.sv
// Run-control and watchdog block: core reset sequencing, run cycle counter, confirmed halt and timeout.
// Optional macro RUN_MON_PC_CAPTURE_EN latches each channel's pc on its first halt.
module run_monitor #(
  parameter int NUM_CH       = 1,
  parameter int PC_W         = 16,
  parameter int CNT_W        = 32,
  parameter int CYCLES_LIMIT = 100000,
  parameter int RST_HOLD     = 3,
  parameter int HALT_CONFIRM = 2,
  parameter int HALT_MODE    = 0
) (
  input  logic           clk,
  input  logic           rst,
  run_monitor_if.slave   bus
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int CONF_W = $clog2(HALT_CONFIRM + 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    RUN,
    CONFIRM,
    DONE,
    TIMEOUT
  } state_t;

  state_t              state_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [CONF_W-1:0]   conf_cnt;
  logic                core_rst_n_q;
  logic                running_q;
  logic                done_q;
  logic                timeout_q;
  logic [CNT_W-1:0]    cycles_q;
  logic [NUM_CH-1:0]   mask_q;

  logic                cond;
  logic                active;
  logic                restart;
  logic [CNT_W-1:0]    cycles_inc;
  logic [CONF_W-1:0]   conf_next;
  logic                conf_hit;
  logic                limit_hit;

  always_comb begin
    cond       = (HALT_MODE != 0) ? (|bus.halt) : (&bus.halt);
    active     = (state_q == RUN) || (state_q == CONFIRM);
    restart    = bus.start &&
                 ((state_q == IDLE) || (state_q == DONE) || (state_q == TIMEOUT));
    cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
    // Entering from RUN the halt cycle itself counts as the first confirm.
    conf_next  = (state_q == CONFIRM) ? conf_cnt + CONF_W'(1) : CONF_W'(1);
    conf_hit   = cond && (conf_next == CONF_W'(HALT_CONFIRM));
    limit_hit  = (CYCLES_LIMIT != 0) && (cycles_inc == CNT_W'(CYCLES_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_cnt     <= '0;
      conf_cnt     <= '0;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      cycles_q     <= '0;
      mask_q       <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, TIMEOUT: begin
          if (restart) begin
            state_q      <= HOLD;
            hold_cnt     <= '0;
            conf_cnt     <= '0;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            cycles_q     <= '0;
            mask_q       <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            state_q      <= RUN;
            hold_cnt     <= '0;
            core_rst_n_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN, CONFIRM: begin
          cycles_q <= cycles_inc;
          mask_q   <= mask_q | bus.halt;
          // A confirming halt takes priority over a limit hit in the same cycle.
          if (conf_hit) begin
            state_q   <= DONE;
            conf_cnt  <= '0;
            done_q    <= 1'b1;
            running_q <= 1'b0;
          end else if (limit_hit) begin
            state_q   <= TIMEOUT;
            conf_cnt  <= '0;
            timeout_q <= 1'b1;
            running_q <= 1'b0;
          end else if (cond) begin
            state_q  <= CONFIRM;
            conf_cnt <= conf_next;
          end else begin
            state_q  <= RUN;
            conf_cnt <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RUN_MON_PC_CAPTURE_EN
  logic [NUM_CH*PC_W-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else if (restart) begin
      pc_q <= '0;
    end else if (active) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.halt[i] && !mask_q[i]) begin
          pc_q[i*PC_W +: PC_W] <= bus.pc[i*PC_W +: PC_W];
        end
      end
    end
  end

  assign bus.halt_pc = pc_q;
`else
  assign bus.halt_pc = '0;
`endif

  assign bus.core_rst_n = core_rst_n_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.timeout    = timeout_q;
  assign bus.cycles     = cycles_q;
  assign bus.halt_mask  = mask_q;

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: ALL-mode watchdog and ANY-mode instance with a narrow counter.
module tb_run_monitor;

`ifdef RUN_MON_PC_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_d = 1'b0;
  logic [1:0]  halt_d = '0;
  logic [31:0] pc_d = '0;

  always #5 clk = ~clk;

  run_monitor_if #(.NUM_CH(2), .PC_W(16), .CNT_W(32)) if_all ();
  run_monitor_if #(.NUM_CH(2), .PC_W(16), .CNT_W(4))  if_any ();

  assign if_all.start = start_d;
  assign if_all.halt  = halt_d;
  assign if_all.pc    = pc_d;
  assign if_any.start = start_d;
  assign if_any.halt  = halt_d;
  assign if_any.pc    = pc_d;

  run_monitor #(.NUM_CH(2), .PC_W(16), .CNT_W(32), .CYCLES_LIMIT(20),
                .RST_HOLD(3), .HALT_CONFIRM(2), .HALT_MODE(0))
    u_all (.clk(clk), .rst(rst), .bus(if_all));

  run_monitor #(.NUM_CH(2), .PC_W(16), .CNT_W(4), .CYCLES_LIMIT(0),
                .RST_HOLD(1), .HALT_CONFIRM(1), .HALT_MODE(1))
    u_any (.clk(clk), .rst(rst), .bus(if_any));

  int checks = 0;
  int errors = 0;
  bit need_rst = 1'b0;

  // Stimulus trace indexed by cycle after the start edge (t = 1 ..).
  logic [1:0]  ht  [64];
  logic [15:0] pct [2][64];

  // Per-instance configuration and reference outcome of the current run.
  int          m_rh   [2] = '{3, 1};
  int          m_mode [2] = '{0, 1};
  int          m_hc   [2] = '{2, 1};
  int          m_lim  [2] = '{20, 0};
  logic [63:0] m_sat  [2] = '{64'hFFFF_FFFF, 64'hF};
  int          m_endk [2];
  bit          m_isd  [2];
  bit          m_ist  [2];
  int          m_fk   [2][2];

  typedef struct {
    int a0; int l0; int b0;
    int a1; int l1; int b1;
    int start_at;
    bit e_done; bit e_to; int e_cyc; logic [1:0] e_mask; int e_fk0; int e_fk1;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fetch(input int id, output logic crn, output logic run, output logic dn,
                       output logic to, output logic [63:0] cyc, output logic [1:0] msk,
                       output logic [31:0] hpc);
    if (id == 0) begin
      crn = if_all.core_rst_n; run = if_all.running; dn = if_all.done; to = if_all.timeout;
      cyc = 64'(if_all.cycles); msk = if_all.halt_mask; hpc = if_all.halt_pc;
    end else begin
      crn = if_any.core_rst_n; run = if_any.running; dn = if_any.done; to = if_any.timeout;
      cyc = 64'(if_any.cycles); msk = if_any.halt_mask; hpc = if_any.halt_pc;
    end
  endtask

  task automatic check_zero(input int id, input string tag);
    logic crn, run, dn, to; logic [63:0] cyc; logic [1:0] msk; logic [31:0] hpc;
    string n;
    fetch(id, crn, run, dn, to, cyc, msk, hpc);
    n = $sformatf("%s dut%0d", tag, id);
    chk({n, " core_rst_n"}, 64'(crn), 64'd0);
    chk({n, " running"},    64'(run), 64'd0);
    chk({n, " done"},       64'(dn),  64'd0);
    chk({n, " timeout"},    64'(to),  64'd0);
    chk({n, " cycles"},     cyc,      64'd0);
    chk({n, " halt_mask"},  64'(msk), 64'd0);
    chk({n, " halt_pc"},    64'(hpc), 64'd0);
  endtask

  // Outcome from the rules: the run ends on the first run cycle where the
  // trailing streak of cond reaches HALT_CONFIRM, else at the cycle limit.
  task automatic run_model(input int id, input int total);
    int streak;
    logic [1:0] h;
    logic c;
    streak = 0; m_endk[id] = 0; m_isd[id] = 0; m_ist[id] = 0;
    m_fk[id][0] = 0; m_fk[id][1] = 0;
    for (int k = 1; (m_rh[id] + k <= total) && (m_endk[id] == 0); k++) begin
      h = ht[m_rh[id] + k];
      for (int ch = 0; ch < 2; ch++)
        if (h[ch] && m_fk[id][ch] == 0) m_fk[id][ch] = k;
      c = (m_mode[id] != 0) ? |h : &h;
      streak = c ? streak + 1 : 0;
      if (streak >= m_hc[id]) begin
        m_endk[id] = k; m_isd[id] = 1'b1;
      end else if (m_lim[id] != 0 && k == m_lim[id]) begin
        m_endk[id] = k; m_ist[id] = 1'b1;
      end
    end
  endtask

  task automatic check_cycle(input int id, input int t);
    int k, kk, endk;
    bit ended;
    logic e_crn, e_run, e_dn, e_to;
    logic [63:0] e_cyc;
    logic [1:0] e_msk;
    logic [31:0] e_pc;
    logic crn, run, dn, to; logic [63:0] cyc; logic [1:0] msk; logic [31:0] hpc;
    string n;
    endk  = m_endk[id];
    ended = (endk != 0);
    k     = t - m_rh[id];
    kk    = (ended && k > endk) ? endk : k;
    if (kk < 0) kk = 0;
    e_crn = (t >= m_rh[id]);
    e_run = !(ended && k >= endk);
    e_dn  = ended && m_isd[id] && (k >= endk);
    e_to  = ended && m_ist[id] && (k >= endk);
    e_cyc = (64'(kk) > m_sat[id]) ? m_sat[id] : 64'(kk);
    e_pc  = '0;
    for (int ch = 0; ch < 2; ch++) begin
      e_msk[ch] = (m_fk[id][ch] != 0) && (m_fk[id][ch] <= kk);
      if (CAP && e_msk[ch]) e_pc[ch*16 +: 16] = pct[ch][m_rh[id] + m_fk[id][ch]];
    end
    fetch(id, crn, run, dn, to, cyc, msk, hpc);
    n = $sformatf("dut%0d t%0d", id, t);
    chk({n, " core_rst_n"}, 64'(crn), 64'(e_crn));
    chk({n, " running"},    64'(run), 64'(e_run));
    chk({n, " done"},       64'(dn),  64'(e_dn));
    chk({n, " timeout"},    64'(to),  64'(e_to));
    chk({n, " cycles"},     cyc,      e_cyc);
    chk({n, " halt_mask"},  64'(msk), 64'(e_msk));
    chk({n, " halt_pc"},    64'(hpc), 64'(e_pc));
  endtask

  task automatic run_trace(input int total, input int start_at);
    if (need_rst) begin
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
    end
    run_model(0, total);
    run_model(1, total);
    @(negedge clk); start_d = 1'b1; halt_d = '0;
    for (int t = 1; t <= total; t++) begin
      @(negedge clk);
      start_d = (t == start_at);
      halt_d  = ht[t];
      pc_d    = {pct[1][t], pct[0][t]};
      @(posedge clk); #1;
      check_cycle(0, t);
      check_cycle(1, t);
    end
    @(negedge clk); start_d = 1'b0; halt_d = '0;
    need_rst = (m_endk[0] == 0) || (m_endk[1] == 0);
  endtask

  function automatic bit on(input int k, input int a, input int l, input int b);
    return (l != 0 && k >= a && k < a + l) || (b != 0 && k >= b);
  endfunction

  task automatic random_pcs();
    for (int t = 0; t < 64; t++) begin
      pct[0][t] = 16'($urandom);
      pct[1][t] = 16'($urandom);
    end
  endtask

  initial begin
    // a0 l0 b0 | a1 l1 b1 | start_at | done to cycles mask fk0 fk1 (run cycles of u_all)
    vt[0] = '{0, 0, 5,  0, 0, 5,  0, 1'b1, 1'b0, 6,  2'b11, 5,  5};
    vt[1] = '{4, 1, 9,  4, 1, 9,  2, 1'b1, 1'b0, 10, 2'b11, 4,  4};
    vt[2] = '{0, 0, 3,  0, 0, 7,  0, 1'b1, 1'b0, 8,  2'b11, 3,  7};
    vt[3] = '{0, 0, 0,  0, 0, 0,  6, 1'b0, 1'b1, 20, 2'b00, 0,  0};
    vt[4] = '{0, 0, 0,  0, 0, 2,  0, 1'b0, 1'b1, 20, 2'b10, 0,  2};
    vt[5] = '{0, 0, 20, 0, 0, 20, 0, 1'b0, 1'b1, 20, 2'b11, 20, 20};
    vt[6] = '{0, 0, 19, 0, 0, 19, 0, 1'b1, 1'b0, 20, 2'b11, 19, 19};

    repeat (3) @(posedge clk);
    #1;
    check_zero(0, "reset");
    check_zero(1, "reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check_zero(0, "idle");
    check_zero(1, "idle");

    for (int i = 0; i < 7; i++) begin
      random_pcs();
      for (int t = 0; t < 64; t++) begin
        ht[t] = '0;
        if (t > 3) begin
          ht[t][0] = on(t - 3, vt[i].a0, vt[i].l0, vt[i].b0);
          ht[t][1] = on(t - 3, vt[i].a1, vt[i].l1, vt[i].b1);
        end
      end
      run_trace(25, vt[i].start_at);
      chk($sformatf("vec%0d done", i),      64'(if_all.done),      64'(vt[i].e_done));
      chk($sformatf("vec%0d timeout", i),   64'(if_all.timeout),   64'(vt[i].e_to));
      chk($sformatf("vec%0d cycles", i),    64'(if_all.cycles),    64'(vt[i].e_cyc));
      chk($sformatf("vec%0d halt_mask", i), 64'(if_all.halt_mask), 64'(vt[i].e_mask));
      chk($sformatf("vec%0d halt_pc0", i),  64'(if_all.halt_pc[15:0]),
          (CAP && vt[i].e_fk0 != 0) ? 64'(pct[0][3 + vt[i].e_fk0]) : 64'd0);
      chk($sformatf("vec%0d halt_pc1", i),  64'(if_all.halt_pc[31:16]),
          (CAP && vt[i].e_fk1 != 0) ? 64'(pct[1][3 + vt[i].e_fk1]) : 64'd0);
    end

    for (int r = 0; r < 40; r++) begin
      int dens;
      dens = $urandom_range(0, 3);
      random_pcs();
      for (int t = 0; t < 64; t++) begin
        if (dens == 0) ht[t] = '0;
        else if ($urandom_range(0, 3) < dens) ht[t] = 2'b11;
        else ht[t] = 2'($urandom_range(0, 2));
      end
      run_trace(25, 0);
    end

    // Reset while u_all sits in CONFIRM must return both instances to idle at once.
    random_pcs();
    for (int t = 0; t < 64; t++) ht[t] = (t >= 8) ? 2'b11 : 2'b00;
    run_trace(8, 0);
    rst = 1'b1;
    #1;
    check_zero(0, "rst_in_confirm");
    check_zero(1, "rst_in_confirm");
    @(negedge clk); rst = 1'b0;
    need_rst = 1'b0;
    @(posedge clk); #1;
    check_zero(0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run-control and watchdog block; successor to the bench-level clock/reset/halt/cycle-limit logic.
- Sequences core reset after a start pulse and counts run cycles.
- Detects confirmed halt across NUM_CH cores, with ALL or ANY combine mode, or a cycle-limit timeout.
- Sits between the top-level clock/reset and one or more cpu instances. Exposes done/timeout/cycle count to the bench or a debug register file.

Parameters:
- NUM_CH, 1, number of monitored cores (halt/pc channels), 1..8
- PC_W, 16, width of each core pc
- CNT_W, 32, cycle counter width
- CYCLES_LIMIT, 100000, run cycles before timeout; 0 disables timeout; must be < 2^CNT_W
- RST_HOLD, 3, cycles core_rst_n held low after start, >=1
- HALT_CONFIRM, 2, consecutive cycles halt condition must hold, >=1
- HALT_MODE, 0, 0 = all channels halted, 1 = any channel halted

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle run request
- halt  in  NUM_CH  per-core halt, level
- pc  in  NUM_CH*PC_W  per-core pc, channel i at [i*PC_W +: PC_W]
- core_rst_n  out  1  active-low reset to cores, registered
- running  out  1  high in HOLD, RUN, CONFIRM
- done  out  1  sticky, confirmed halt
- timeout  out  1  sticky, limit reached
- cycles  out  CNT_W  run cycle count
- halt_mask  out  NUM_CH  sticky per-channel halt seen
- halt_pc  out  NUM_CH*PC_W  pc captured at each channel's first halt (see optional feature)

Behaviour:
- Async reset: state IDLE; core_rst_n=0; running=0; done=0; timeout=0; cycles=0; halt_mask=0; halt_pc=0; internal counters 0.
- States: IDLE, HOLD, RUN, CONFIRM, DONE, TIMEOUT. All outputs are registered.
- IDLE: start=1 -> HOLD. Clears cycles, halt_mask, halt_pc, done and timeout.
- DONE/TIMEOUT: behave like IDLE on start (restart).
- HOLD, RUN, CONFIRM: start is ignored.
- HOLD: core_rst_n=0 for exactly RST_HOLD cycles, then -> RUN. core_rst_n=1 on the first RUN cycle and stays 1 until the next HOLD or rst.
- cond = HALT_MODE ? |halt : &halt, using live inputs.
- RUN: cycles += 1 every cycle.
  - cond=1 -> CONFIRM with confirm count 1.
  - If HALT_CONFIRM==1, go straight to DONE instead.
- CONFIRM: cycles keeps incrementing.
  - cond=1: confirm count += 1. On reaching HALT_CONFIRM -> DONE.
  - cond=0: -> RUN, confirm count cleared (glitch rejection).
- Timeout: in RUN/CONFIRM, when the next cycles value equals CYCLES_LIMIT (and CYCLES_LIMIT != 0) -> TIMEOUT, timeout=1.
  - A halt confirming in the same cycle wins: DONE, timeout stays 0.
- DONE: done=1, running=0, cycles frozen.
- TIMEOUT: timeout=1, running=0, cycles frozen.
- cycles saturates at all-ones and never wraps.
- halt_mask[i] is set when halt[i]=1 in RUN or CONFIRM. It holds until the next HOLD entry or rst, and is independent of the confirm filter.
- rst mid-run returns immediately to IDLE with the reset values above; core_rst_n asserts asynchronously.

Optional Feature:
- Macro: RUN_MON_PC_CAPTURE_EN.
- Defined: on the cycle halt_mask[i] first sets, halt_pc channel i latches pc channel i. Later halts do not update it until the next HOLD.
- Undefined: halt_pc is tied to 0 and no capture registers are inferred.

Test Plan:
- NUM_CH=1, RST_HOLD=3, HALT_CONFIRM=2, limit 20; rst, start; halt rises on run cycle 5 and holds -> core_rst_n low 3 cycles; done=1 two cycles after halt; cycles=6 frozen; timeout=0.
- Same config; halt pulses 1 cycle at run cycle 4, then steady from cycle 9 -> CONFIRM aborts back to RUN; done after cycle 10; halt_mask=1 from cycle 4.
- NUM_CH=2, HALT_MODE=0; halt[0] steady at 3, halt[1] at 7 -> done only after halt[1] confirmed; halt_mask=2'b11. With PC capture: halt_pc holds each channel's pc at cycles 3 and 7.
- Limit 20, halt never asserted -> timeout=1 with cycles=20; done=0; start -> HOLD, all sticky outputs cleared.
- Halt confirms exactly on the cycle cycles reaches 20 -> done=1, timeout=0.
- rst asserted in CONFIRM -> immediate IDLE, core_rst_n=0, done=0, cycles=0; start pulse during RUN -> ignored, cycles continues.
